// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end definitions: widths, branch encodings, sequencer
// states, flag bit positions and the sequential PC increment.
package legv8_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned CNT_W  = 3;

  // Bit positions inside the {N,Z,V,C} flags register
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [2:0] {
    BR_B    = 3'b000,
    BR_EQ   = 3'b001,
    BR_NE   = 3'b010,
    BR_LT   = 3'b011,
    BR_GE   = 3'b100,
    BR_CBZ  = 3'b101,
    BR_CBNZ = 3'b110,
    BR_BR   = 3'b111
  } br_type_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } seq_state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator (purely combinational).
//   flags   : registered {N,Z,V,C}
//   br_type : branch encoding
//   br_reg  : tested register value for CBZ/CBNZ
//   cond_c  : branch condition holds
module branch_cond
  import legv8_pkg::*;
(
  input  logic [FLAG_W-1:0] flags,
  input  br_type_t          br_type,
  input  logic [XLEN-1:0]   br_reg,
  output logic              cond_c
);

  always_comb begin
    cond_c = 1'b0;
    case (br_type)
      BR_B, BR_BR: cond_c = 1'b1;
      BR_EQ:       cond_c = flags[FLAG_Z];
      BR_NE:       cond_c = !flags[FLAG_Z];
      BR_LT:       cond_c = flags[FLAG_N] != flags[FLAG_V];
      BR_GE:       cond_c = flags[FLAG_N] == flags[FLAG_V];
      BR_CBZ:      cond_c = br_reg == '0;
      BR_CBNZ:     cond_c = br_reg != '0;
      default:     cond_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// PC / branch-resolution controller: owns PC and NZVC flags, resolves
// execute-stage branches, redirects fetch and holds a fixed flush window.
//   clk, reset        : clock, synchronous active-high reset
//   imem_ready        : fetch at pc accepted this cycle
//   flag_we, alu_*    : flag update from execute
//   br_valid/type/pc/offset/reg : resolving branch
//   pc, fetch_valid   : fetch address / request
//   flush             : squash IF/ID (high while in FLUSH)
//   taken             : combinational branch-taken indication
//   flags             : {N,Z,V,C}
//   align_err         : sticky misaligned-target flag
module branch_sequencer
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic        flag_we,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_c,
  input  logic        br_valid,
  input  logic [2:0]  br_type,
  input  logic [63:0] br_pc,
  input  logic [63:0] br_offset,
  input  logic [63:0] br_reg,
  output logic [63:0] pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        taken,
  output logic [3:0]  flags,
  output logic        align_err
);

  // Flush window length must fit the 3-bit counter and be nonzero
  if (FLUSH_CYCLES == 0 || FLUSH_CYCLES > 7) begin : g_cfg_err
    $error("branch_sequencer: FLUSH_CYCLES must be in 1..7");
  end

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              align_q, align_d;

  br_type_t          br_type_e;
  logic              cond_c;
  logic [XLEN-1:0]   target_raw;

  assign br_type_e = br_type_t'(br_type);

  branch_cond u_branch_cond (
    .flags   (flags_q),
    .br_type (br_type_e),
    .br_reg  (br_reg),
    .cond_c  (cond_c)
  );

  // Branches seen during FLUSH are wrong-path and never taken
  assign taken = br_valid && cond_c && (state_q == RUN);

  // Relative targets wrap modulo 2^64
  assign target_raw = (br_type_e == BR_BR) ? br_reg : (br_pc + br_offset);

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    align_d = align_q;
    flags_d = flag_we ? {alu_n, alu_z, alu_v, alu_c} : flags_q;

    case (state_q)
      RUN: begin
        if (taken) begin
          pc_d    = {target_raw[XLEN-1:2], 2'b00};
          cnt_d   = CNT_W'(FLUSH_CYCLES);
          state_d = FLUSH;
          if (target_raw[1:0] != 2'b00) align_d = 1'b1;
        end else if (imem_ready) begin
          pc_d = pc_q + XLEN'(PC_INC);
        end
      end
      FLUSH: begin
        // Last flush cycle when the counter reads 1
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      flags_q <= '0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      align_q <= align_d;
    end
  end

  assign pc          = pc_q;
  assign flags       = flags_q;
  assign align_err   = align_q;
  assign flush       = (state_q == FLUSH);
  // Fetch is suppressed while reset is held, live again the cycle after
  assign fetch_valid = (state_q == RUN) && !reset;

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Program-counter and branch-resolution controller for the 64-bit LEGv8 core. It owns the PC register and the NZVC flags register, and evaluates branch conditions from the execute stage (B, B.cond, CBZ/CBNZ, BR). It redirects fetch on taken branches and sequences a fixed flush window so that wrong-path instructions are squashed. It sits between the instruction-memory port and the execute stage, replacing the free-running PC+4 logic.

## Interface
Parameters:
- `RESET_PC`, 64'h0, PC value loaded by reset.
- `FLUSH_CYCLES`, 2, number of cycles with `flush` high after a taken branch (1..7).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `imem_ready`  in  1  instruction memory accepts the fetch at `pc` this cycle.
- `flag_we`  in  1  execute-stage flag-setting op (ADDS/SUBS/ANDS) completes.
- `alu_n`, `alu_z`, `alu_v`, `alu_c`  in  1 each  ALU flags to capture on `flag_we`.
- `br_valid`  in  1  a branch is resolving in execute this cycle.
- `br_type`  in  3  000 B, 001 B.EQ, 010 B.NE, 011 B.LT, 100 B.GE, 101 CBZ, 110 CBNZ, 111 BR.
- `br_pc`  in  64  address of the resolving branch.
- `br_offset`  in  64  sign-extended byte offset (already shifted by 2).
- `br_reg`  in  64  register operand: the target for BR, the tested value for CBZ/CBNZ.
- `pc`  out  64  current fetch address (registered).
- `fetch_valid`  out  1  fetch request to instruction memory.
- `flush`  out  1  squash IF/ID contents (registered).
- `taken`  out  1  combinational: the current `br_valid` branch is taken.
- `flags`  out  4  {N,Z,V,C} register.
- `align_err`  out  1  sticky: a taken target had a nonzero value in bits [1:0].

## Operation
- Condition evaluation (combinational, uses the registered `flags`):
  - B and BR: always taken.
  - EQ: Z. NE: !Z. LT: N!=V. GE: N==V.
  - CBZ: `br_reg`==0. CBNZ: `br_reg`!=0.
- `taken` = `br_valid` & condition & (state==RUN).
- Target:
  - BR: `br_reg`.
  - All others: `br_pc`+`br_offset`, modulo 2^64; wrap-around is legal and silent.
  - The loaded PC is the target with bits [1:0] forced to 0. If the raw target has nonzero bits [1:0], `align_err` is set and stays set until reset.
- Flags register: loads {alu_n,alu_z,alu_v,alu_c} on `flag_we`, otherwise holds. When `flag_we` and `br_valid` are both high, the condition uses the old flags and the flags still update.
- State machine:
  - RUN: `fetch_valid`=1. If `taken`: `pc`<=target, flush counter <= FLUSH_CYCLES, go to FLUSH. Else, if `imem_ready`: `pc`<=`pc`+4. Else `pc` holds (stall).
  - FLUSH: `fetch_valid`=0, `flush`=1, `pc` holds, counter decrements each cycle, return to RUN when the counter reaches 1. `br_valid` is ignored in FLUSH (its instruction is wrong-path) and `taken`=0.
- A taken branch has priority over PC+4 even when `imem_ready`=1.

## Timing
- Reset values: `pc`=RESET_PC, `flags`=4'b0000, `flush`=0, `align_err`=0, state=RUN, counter=0.
- `fetch_valid`=0 while `reset` is high, and 1 in the first cycle after reset.
- Reset mid-flush aborts the flush: on the next cycle the state is RUN and `pc`=RESET_PC.
- Branch latency: `taken` in cycle t gives `pc`=target and `flush`=1 in cycles t+1 .. t+FLUSH_CYCLES. Fetch at the target starts in cycle t+FLUSH_CYCLES+1.
- `imem_ready` low in RUN holds `pc` indefinitely. A branch during the stall is still taken.
- Flags written in cycle t are visible to a branch in cycle t+1.

## Structure
- Shared package `legv8_pkg`:
  - `br_type_t` enum (the 8 encodings above).
  - `seq_state_t` {RUN, FLUSH}.
  - Flag bit-index constants (N=3, Z=2, V=1, C=0).
  - `PC_INC`=4.
- Sub-module `branch_cond`: purely combinational; flags, `br_type`, `br_reg` in, condition bit out. Instantiated once.
- The counter is 3 bits wide. FLUSH_CYCLES outside 1..7 is a configuration error and is checked at elaboration.

## Test plan
- Reset, then `imem_ready`=1 for 4 cycles -> `pc` = 0, 4, 8, C, 10. `flags`=0 and `fetch_valid`=1 throughout.
- `flag_we` with Z=1, then next cycle `br_valid`, B.EQ, `br_pc`=0x100, `br_offset`=0x40 -> `taken`=1. Then `pc`=0x140, `flush`=1 for 2 cycles, `fetch_valid`=0 for 2 cycles, and fetch resumes at 0x140.
- CBNZ with `br_reg`=0 -> `taken`=0 and `pc` advances by 4. CBZ with `br_reg`=0 -> taken.
- B.LT with N=1, V=0 -> taken. B.GE with the same flags -> not taken.
- BR with `br_reg`=0x2002 -> `pc`=0x2000 and `align_err`=1, still 1 after 10 further cycles.
- Branch during `imem_ready`=0 -> redirect. `br_valid` during FLUSH -> ignored. `br_pc`=0xFFFF_FFFF_FFFF_FFF0 with offset 0x20 -> `pc`=0x10. Reset asserted in the 2nd flush cycle -> `pc`=0, RUN.
